// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: drives the PLL RESET pin, filters LOCK, retries on timeout and
// releases the per-channel output-domain resets one by one.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLLRST    | pll_reset_o asserted for PLL_RST_CYC cycles
// WAITLOCK  | reset released, waiting up to LOCK_TIMEOUT for lock_s
// FILTER    | lock_s must stay high for LOCK_FILT consecutive cycles
// RELEASE   | channel resets released CH_STAGGER cycles apart
// RUN       | all channels out of reset, watching for lock loss
// FAULT     | retries exhausted, PLL held in reset until restart
module pll_reset_sequencer #(
    parameter int NUM_CH       = 3,
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_FILT    = 256,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CH_STAGGER   = 64,
    parameter int MAX_RETRY    = 3
) (
    input  logic                           clkin,
    input  logic                           rst_n,
    input  logic                           pll_lock_i,
    input  logic                           sw_restart_i,
    output logic                           pll_reset_o,
    output logic [NUM_CH-1:0]              ch_rst_n_o,
    output logic                           ready_o,
    output logic                           fault_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

    localparam int RW      = $clog2(MAX_RETRY + 1);
    localparam int M1      = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int M2      = (M1 > LOCK_FILT) ? M1 : LOCK_FILT;
    localparam int CH_SPAN = NUM_CH * CH_STAGGER;
    localparam int CNT_MAX = (M2 > CH_SPAN) ? M2 : CH_SPAN;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'((NUM_CH > 1) ? (NUM_CH - 1) * CH_STAGGER - 1 : 0);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PLLRST, S_WAITLOCK, S_FILTER, S_RELEASE, S_RUN, S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               cnt_clr;
    logic [RW-1:0]      retry_q, retry_d;
    logic               lock_meta_q, lock_s_q;
    logic               pll_reset_q, pll_reset_d;
    logic [NUM_CH-1:0]  ch_rst_n_q, ch_rst_n_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= S_PLLRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            ch_rst_n_q  <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            ch_rst_n_q  <= ch_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_clr = 1'b0;
        if (sw_restart_i) begin
            // Also clears cnt when already in PLLRST so the full pulse is reapplied.
            state_d = S_PLLRST;
            retry_d = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_PLLRST: begin
                    if (cnt_q == RST_LAST) state_d = S_WAITLOCK;
                end
                S_WAITLOCK: begin
                    if (lock_s_q) begin
                        state_d = S_FILTER;
                    end else if (cnt_q == TO_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_PLLRST;
                            retry_d = retry_q + RW'(1);
                        end
                    end
                end
                S_FILTER: begin
                    if (!lock_s_q) begin
                        state_d = S_WAITLOCK;
                    end else if (cnt_q == FILT_LAST) begin
                        if (NUM_CH == 1) begin
                            state_d = S_RUN;
                            retry_d = '0;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!lock_s_q) begin
                        state_d = S_PLLRST;
                    end else if (cnt_q == REL_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) state_d = S_PLLRST;
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_PLLRST;
                end
            endcase
        end
        if (state_d != state_q) cnt_clr = 1'b1;
        if (cnt_clr)             cnt_d = '0;
        else if (cnt_q == '1)    cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CW'(1);
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        pll_reset_d = (state_d == S_PLLRST) || (state_d == S_FAULT);
        fault_d     = (state_d == S_FAULT);
        ready_d     = (state_d == S_RUN);
        ch_rst_n_d  = '0;
        case (state_d)
            S_RUN: ch_rst_n_d = '1;
            S_RELEASE: begin
                ch_rst_n_d[0] = 1'b1;
                for (int k = 1; k < NUM_CH; k++) begin
                    ch_rst_n_d[k] = (cnt_d >= CW'(k * CH_STAGGER));
                end
            end
            default: ch_rst_n_d = '0;
        endcase
    end

    assign pll_reset_o = pll_reset_q;
    assign ch_rst_n_o  = ch_rst_n_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_q;

endmodule
